// File: rtl/mesi_isc_fifo_pkg.sv
// Shared constants and width helpers for the MESI ISC parameterised FIFO.
// Default parameter values live here so the top and the storage agree.
package mesi_isc_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_SIZE  = 4;
    localparam int DEF_AFULL_LVL  = 3;
    localparam int DEF_AEMPTY_LVL = 1;

    // The count must represent 0..size inclusive, hence size+1 codes.
    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/mesi_isc_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port and
// one asynchronous read port so the head entry is visible without latency.
module mesi_isc_fifo_mem
    import mesi_isc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_SIZE,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // controller's count, and a resettable array would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mesi_isc_param_fifo.sv
// Parameterised show-ahead FIFO with registered count and status flags.
// Define MESI_ISC_FIFO_DBG_EN to add sticky overflow/underflow debug outputs.
module mesi_isc_param_fifo
    import mesi_isc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
    parameter int AFULL_LVL  = DEF_AFULL_LVL,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL,
    localparam int CNT_W     = cnt_w(FIFO_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  status_empty_o,
    output logic                  status_full_o,
    output logic                  status_aempty_o,
    output logic                  status_afull_o,
    output logic [CNT_W-1:0]      count_o
`ifdef MESI_ISC_FIFO_DBG_EN
    ,
    output logic                  dbg_overflow_o,
    output logic                  dbg_underflow_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_SIZE);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  empty;
    logic                  full;
    logic                  aempty;
    logic                  afull;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] head;

    // Explicit wrap so non-power-of-two depths never rely on overflow.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_ok      = wr_i & (~full | rd_i);
    assign rd_ok      = rd_i & ~empty;
    assign count_next = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            aempty <= 1'b1;
            afull  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= bump(wr_ptr);
            if (rd_ok) rd_ptr <= bump(rd_ptr);
            count  <= count_next;
            empty  <= (count_next == '0);
            full   <= (count_next == CNT_W'(FIFO_SIZE));
            aempty <= (count_next <= CNT_W'(AEMPTY_LVL));
            afull  <= (count_next >= CNT_W'(AFULL_LVL));
        end
    end

    mesi_isc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Stale storage must never leak out while the FIFO holds nothing.
    assign data_o          = empty ? '0 : head;
    assign status_empty_o  = empty;
    assign status_full_o   = full;
    assign status_aempty_o = aempty;
    assign status_afull_o  = afull;
    assign count_o         = count;

`ifdef MESI_ISC_FIFO_DBG_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_i & full & ~rd_i) overflow  <= 1'b1;
            if (rd_i & empty)        underflow <= 1'b1;
        end
    end

    assign dbg_overflow_o  = overflow;
    assign dbg_underflow_o = underflow;
`else
    // Dropped writes and ignored reads have no observer in this build.
`endif

endmodule

// File: tb/tb_mesi_isc_param_fifo.sv
// Self-checking bench for mesi_isc_param_fifo: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mesi_isc_param_fifo;

    localparam int DW    = 8;
    localparam int SIZE  = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(SIZE + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          empty_s;
    logic          full_s;
    logic          aempty_s;
    logic          afull_s;
    logic [CW-1:0] cnt;
`ifdef MESI_ISC_FIFO_DBG_EN
    logic          ovf_s;
    logic          unf_s;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    mesi_isc_param_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_SIZE  (SIZE),
        .AFULL_LVL  (AF),
        .AEMPTY_LVL (AE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_i            (wr),
        .rd_i            (rd),
        .data_i          (din),
        .data_o          (dout),
        .status_empty_o  (empty_s),
        .status_full_o   (full_s),
        .status_aempty_o (aempty_s),
        .status_afull_o  (afull_s),
        .count_o         (cnt)
`ifdef MESI_ISC_FIFO_DBG_EN
        ,
        .dbg_overflow_o  (ovf_s),
        .dbg_underflow_o (unf_s)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding exactly the valid entries.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_full;
    bit            m_empty;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_full  = (q.size() == SIZE);
            m_empty = (q.size() == 0);
            if (wr && m_full && !rd) m_ovf = 1;
            if (rd && m_empty)       m_unf = 1;
            if (rd && !m_empty)            void'(q.pop_front());
            if (wr && (!m_full || rd))     q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_count",  32'(cnt),      32'(q.size()));
            check("cmp_empty",  32'(empty_s),  32'(q.size() == 0));
            check("cmp_full",   32'(full_s),   32'(q.size() == SIZE));
            check("cmp_aempty", 32'(aempty_s), 32'(q.size() <= AE));
            check("cmp_afull",  32'(afull_s),  32'(q.size() >= AF));
            check("cmp_data",   32'(dout),     (q.size() == 0) ? 32'h0 : 32'(q[0]));
`ifdef MESI_ISC_FIFO_DBG_EN
            check("cmp_ovf",    32'(ovf_s),    32'(m_ovf));
            check("cmp_unf",    32'(unf_s),    32'(m_unf));
`endif
        end
    end

    // One clock with the given request; returns at the following falling edge.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic fill_11_15();
        for (int i = 0; i < SIZE; i++) cyc(1'b1, 1'b0, 8'(8'h11 + i));
    endtask

    initial begin
        logic [DW-1:0] exp_drain [SIZE];
        bit            mode_fill;

        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; din = '0;
        @(negedge clk);
        cyc(1'b1, 1'b1, 8'hFF);
        cmp_en = 1;
        rst_n  = 1'b1;

        check("rst_count",  32'(cnt),      32'd0);
        check("rst_empty",  32'(empty_s),  32'd1);
        check("rst_aempty", 32'(aempty_s), 32'd1);
        check("rst_data",   32'(dout),     32'd0);

        // Fill then drain, with flags pinned per step.
        for (int i = 0; i < SIZE; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h11 + i));
            check("s1_count", 32'(cnt),     32'(i + 1));
            check("s1_afull", 32'(afull_s), 32'(i + 1 >= 4));
            check("s1_full",  32'(full_s),  32'(i + 1 == 5));
        end
        for (int i = 0; i < SIZE; i++) begin
            check("s1_data", 32'(dout), 32'(8'h11 + i));
            cyc(1'b0, 1'b1, '0);
        end
        check("s1_empty", 32'(empty_s), 32'd1);

        // Dropped write at full.
        fill_11_15();
        cyc(1'b1, 1'b0, 8'hAA);
        check("s2_count", 32'(cnt),  32'd5);
        check("s2_head",  32'(dout), 32'h11);
`ifdef MESI_ISC_FIFO_DBG_EN
        check("s2_ovf",   32'(ovf_s), 32'd1);
`endif

        // Simultaneous read/write at full.
        cyc(1'b1, 1'b1, 8'h66);
        check("s3_count", 32'(cnt),  32'd5);
        check("s3_head",  32'(dout), 32'h12);
        exp_drain = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h66};
        for (int i = 0; i < SIZE; i++) begin
            check("s3_drain", 32'(dout), 32'(exp_drain[i]));
            cyc(1'b0, 1'b1, '0);
        end

        // Read on empty with a write: no bypass, write lands.
        cyc(1'b1, 1'b1, 8'h3C);
        check("s4_count", 32'(cnt),  32'd1);
        check("s4_data",  32'(dout), 32'h3C);
`ifdef MESI_ISC_FIFO_DBG_EN
        check("s4_unf",   32'(unf_s), 32'd1);
`endif
        cyc(1'b0, 1'b1, '0);

        // Streaming push/pop across pointer wraps.
        cyc(1'b1, 1'b0, 8'hA0);
        for (int i = 0; i < 12; i++) begin
            logic [DW-1:0] prev;
            prev = 8'(8'hA0 + i);
            check("s5_head", 32'(dout), 32'(prev));
            cyc(1'b1, 1'b1, 8'(8'hA1 + i));
        end
        check("s5_count", 32'(cnt), 32'd1);
        cyc(1'b0, 1'b1, '0);

        // Reset mid-traffic.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        check("s6_pre", 32'(cnt), 32'd3);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 8'h99);
        rst_n = 1'b1;
        check("s6_count",  32'(cnt),      32'd0);
        check("s6_empty",  32'(empty_s),  32'd1);
        check("s6_aempty", 32'(aempty_s), 32'd1);
        check("s6_data",   32'(dout),     32'd0);
        cyc(1'b1, 1'b0, 8'h77);
        check("s6_head",   32'(dout),     32'h77);
        check("s6_cnt1",   32'(cnt),      32'd1);

        // Randomized traffic with alternating fill/drain bias and rare resets.
        mode_fill = 1;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) mode_fill = ~mode_fill;
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 99) < (mode_fill ? 75 : 30)),
                ($urandom_range(0, 99) < (mode_fill ? 30 : 75)),
                8'($urandom));
            rst_n = 1'b1;
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_isc_param_fifo.md
MESI_ISC_PARAM_FIFO -- requirements
Module: mesi_isc_param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the entry and data port width.
REQ-002 Parameter FIFO_SIZE, default 4, SHALL set the entry count; any value >= 2 is legal, and powers of two are not required.
REQ-003 Parameter AFULL_LVL, default 3, SHALL set the almost-full threshold, legal range 1..FIFO_SIZE.
REQ-004 Parameter AEMPTY_LVL, default 1, SHALL set the almost-empty threshold, legal range 0..FIFO_SIZE-1.
REQ-005 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 wr_i  input  1  SHALL request a write of data_i.
REQ-008 rd_i  input  1  SHALL request a pop of the head entry.
REQ-009 data_i  input  DATA_WIDTH  SHALL carry the write data.
REQ-010 data_o  output  DATA_WIDTH  SHALL present the head entry (show-ahead).
REQ-011 status_empty_o / status_full_o  output  1 each  SHALL flag count==0 / count==FIFO_SIZE.
REQ-012 status_aempty_o / status_afull_o  output  1 each  SHALL flag count<=AEMPTY_LVL / count>=AFULL_LVL.
REQ-013 count_o  output  CNT_W  SHALL report the number of valid entries; CNT_W = clog2(FIFO_SIZE+1).

Function
REQ-014 A write SHALL be accepted when wr_i & (!full | rd_i).
REQ-015 A read SHALL be accepted when rd_i & !empty.
REQ-016 A write when full without rd_i SHALL be dropped; storage, pointers and count SHALL be unchanged.
REQ-017 A read when empty SHALL be ignored, including when wr_i is also high; the write is accepted and there is no bypass.
REQ-018 A simultaneous accepted read and write SHALL leave count unchanged, including at full.
REQ-019 Read and write pointers SHALL wrap from FIFO_SIZE-1 to 0 with no modulo-2^n dependence.
REQ-020 count_o and all four status flags SHALL be registered and updated on the same edge as the accepted operation.
REQ-021 data_o SHALL equal the entry at the read pointer whenever !status_empty_o.
REQ-022 Data written at edge N into an empty FIFO SHALL appear on data_o after edge N.
REQ-023 data_o SHALL be 0 while empty.
REQ-024 Order SHALL be strict FIFO with no loss of accepted data.

Reset
REQ-025 When rst_n=0 at a clock edge, pointers, count_o and data_o SHALL become 0, status_empty_o=1, status_full_o=0, status_aempty_o=1 and status_afull_o=0, regardless of wr_i/rd_i.
REQ-026 Reset asserted mid-traffic SHALL discard all entries, and the first write after release SHALL be the new head.

Configuration
REQ-027 With macro MESI_ISC_FIFO_DBG_EN defined, outputs dbg_overflow_o and dbg_underflow_o (1 bit each) SHALL exist as sticky bits, cleared by reset.
REQ-028 dbg_overflow_o SHALL set on a write dropped per REQ-016.
REQ-029 dbg_underflow_o SHALL set on a read ignored per REQ-017.
REQ-030 Without the macro, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package mesi_isc_fifo_pkg SHALL hold the CNT_W computation function and the default-parameter constants.
REQ-032 Storage SHALL be a sub-module mesi_isc_fifo_mem: FIFO_SIZE x DATA_WIDTH, one write port and one asynchronous read port.
REQ-033 Control, pointers and flags SHALL remain in mesi_isc_param_fifo.

Verification
REQ-034 The bench SHALL run with DATA_WIDTH=8, FIFO_SIZE=5, AFULL_LVL=4, AEMPTY_LVL=1 and cover the scenarios below.
REQ-035 Scenario: write 0x11..0x15, then read 5 times. Required: count 1,2,3,4,5; afull at count 4; full at count 5; data_o 0x11..0x15 in order; empty after the last read.
REQ-036 Scenario: full FIFO, wr_i=1 with 0xAA and rd_i=0. Required: count stays 5, 0xAA is never read, and dbg_overflow_o=1 when MESI_ISC_FIFO_DBG_EN is defined.
REQ-037 Scenario: full FIFO, wr_i=rd_i=1 with 0x66. Required: count stays 5, head advances to 0x12, and 0x66 is read last.
REQ-038 Scenario: empty FIFO, wr_i=rd_i=1 with 0x3C. Required: count becomes 1, data_o=0x3C the next cycle, and dbg_underflow_o=1 when the macro is defined.
REQ-039 Scenario: 12 write/read cycles, pointers wrapping past index 4 twice. Required: output sequence equals input sequence and count never exceeds 5.
REQ-040 Scenario: rst_n=0 for one cycle at count 3. Required: count_o=0, empty=1, aempty=1, data_o=0; a following write of 0x77 reads back 0x77.
